// File: rtl/time_set_editor.sv
// time_set_editor: mode-key driven hour/minute/second editor with wrap-around,
// hold-to-repeat on up/down, cancel, and blink/field status for the display.
module time_set_editor #(
    parameter int HOUR_MIN      = 0,
    parameter int HOUR_MAX      = 23,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int BLINK_CYCLES  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_cancel,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] edit_hour,
    output logic [7:0] edit_min,
    output logic [7:0] edit_sec,
    output logic [7:0] hour_set,
    output logic [7:0] min_set,
    output logic [7:0] sec_set,
    output logic       set_valid,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [7:0]    HMIN       = 8'(HOUR_MIN);
    localparam logic [7:0]    HMAX       = 8'(HOUR_MAX);
    localparam logic [HW-1:0] HOLD_N     = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_N      = HW'(REPEAT_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    // Encoding doubles as field_sel: 0=none, 1=hour, 2=min, 3=sec.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2,
        EDIT_SEC  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    edit_hour_q, edit_hour_d, edit_min_q, edit_min_d, edit_sec_q, edit_sec_d;
    logic [7:0]    hour_set_q, hour_set_d, min_set_q, min_set_d, sec_set_q, sec_set_d;
    logic          set_valid_q, set_valid_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rep_q, rep_d;     // past the initial hold delay, now repeating
    logic          lock_q, lock_d;   // key held across a field change: ignore until released
    logic [1:0]    keys_q, keys_d;   // previous {up, down} sample for press detection

    logic [1:0] keys;
    logic       single, step_en;
    logic       hour_ok;

    function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] lo,
                                             input logic [7:0] hi, input logic up);
        if (up) return (v == hi) ? lo : v + 8'd1;
        else    return (v == lo) ? hi : v - 8'd1;
    endfunction

    assign keys   = {key_up, key_down};
    assign single = key_up ^ key_down;
    // cur_hour >= HMIN written as +1 > HMIN so it stays meaningful when HMIN is 0
    assign hour_ok = (({1'b0, cur_hour} + 9'd1) > {1'b0, HMIN}) && (cur_hour <= HMAX);

    // State register and all datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            edit_hour_q <= HMIN;
            edit_min_q  <= '0;
            edit_sec_q  <= '0;
            hour_set_q  <= HMIN;
            min_set_q   <= '0;
            sec_set_q   <= '0;
            set_valid_q <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            hold_cnt_q  <= '0;
            rep_q       <= 1'b0;
            lock_q      <= 1'b0;
            keys_q      <= '0;
        end else begin
            state_q     <= state_d;
            edit_hour_q <= edit_hour_d;
            edit_min_q  <= edit_min_d;
            edit_sec_q  <= edit_sec_d;
            hour_set_q  <= hour_set_d;
            min_set_q   <= min_set_d;
            sec_set_q   <= sec_set_d;
            set_valid_q <= set_valid_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_q       <= rep_d;
            lock_q      <= lock_d;
            keys_q      <= keys_d;
        end
    end

    // Next-state: key priority cancel > mode > up/down, hold-to-repeat, blink
    always_comb begin
        state_d     = state_q;
        edit_hour_d = edit_hour_q;
        edit_min_d  = edit_min_q;
        edit_sec_d  = edit_sec_q;
        hour_set_d  = hour_set_q;
        min_set_d   = min_set_q;
        sec_set_d   = sec_set_q;
        set_valid_d = 1'b0;
        hold_cnt_d  = '0;
        rep_d       = 1'b0;
        lock_d      = lock_q && (keys != 2'b00);
        keys_d      = keys;
        step_en     = 1'b0;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;

        if (state_q == IDLE) begin
            if (key_mode) begin
                edit_hour_d = hour_ok ? cur_hour : HMIN;
                edit_min_d  = (cur_min < 8'd60) ? cur_min : 8'd0;
                edit_sec_d  = (cur_sec < 8'd60) ? cur_sec : 8'd0;
                state_d     = EDIT_HOUR;
                lock_d      = |keys;
            end
        end else if (key_cancel) begin
            state_d = IDLE;
        end else if (key_mode) begin
            lock_d = |keys;
            case (state_q)
                EDIT_HOUR: state_d = EDIT_MIN;
                EDIT_MIN:  state_d = EDIT_SEC;
                default: begin
                    hour_set_d  = edit_hour_q;
                    min_set_d   = edit_min_q;
                    sec_set_d   = edit_sec_q;
                    set_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            endcase
        end else if (single && !lock_q) begin
            if (keys != keys_q) begin
                step_en    = 1'b1;
                hold_cnt_d = HW'(1);
            end else if (!rep_q) begin
                if (hold_cnt_q == HOLD_N) begin
                    step_en    = 1'b1;
                    hold_cnt_d = HW'(1);
                    rep_d      = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end else begin
                rep_d = 1'b1;
                if (hold_cnt_q == REP_N) begin
                    step_en    = 1'b1;
                    hold_cnt_d = HW'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
        end

        if (step_en) begin
            case (state_q)
                EDIT_HOUR: edit_hour_d = wrap_step(edit_hour_q, HMIN, HMAX, key_up);
                EDIT_MIN:  edit_min_d  = wrap_step(edit_min_q, 8'd0, 8'd59, key_up);
                EDIT_SEC:  edit_sec_d  = wrap_step(edit_sec_q, 8'd0, 8'd59, key_up);
                default: ;
            endcase
        end

        // Blink restarts visible on entry, field change or any adjust step
        if (state_d == IDLE) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if ((state_d != state_q) || step_en) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    assign edit_hour = edit_hour_q;
    assign edit_min  = edit_min_q;
    assign edit_sec  = edit_sec_q;
    assign hour_set  = hour_set_q;
    assign min_set   = min_set_q;
    assign sec_set   = sec_set_q;
    assign set_valid = set_valid_q;
    assign editing   = (state_q != IDLE);
    assign field_sel = state_q;
    assign blink     = blink_q;

endmodule

// File: doc/time_set_editor.md
Name: time_set_editor

Overview:
Parametrised successor to the direct-key time setter for the digital-clock design. A mode key steps through an edit sequence: hour, then minute, then second, then commit. In each field, up/down keys adjust the value, with wrap-around and hold-to-repeat. The block loads the live time on entry, supports cancel, and drives display-side status (field select, blink). It sits between the debounced key conditioner and the clock counter, which loads hour_set/min_set/sec_set on set_valid.

Parameters:
HOUR_MIN, 0, lowest hour value; set to 1 for a 12-hour display.
HOUR_MAX, 23, highest hour value; set to 12 for a 12-hour display.
HOLD_CYCLES, 50_000_000, clk cycles a key must be held before auto-repeat starts (>=2).
REPEAT_CYCLES, 10_000_000, clk cycles between auto-repeat steps (>=1).
BLINK_CYCLES, 25_000_000, clk cycles per blink half-period (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_mode  in  1  single-cycle pulse; enter edit / next field / commit
key_cancel  in  1  single-cycle pulse; abort edit
key_up  in  1  debounced level; increment the selected field
key_down  in  1  debounced level; decrement the selected field
cur_hour  in  8  live hour, binary
cur_min  in  8  live minute, binary
cur_sec  in  8  live second, binary
edit_hour  out  8  working hour value, for display
edit_min  out  8  working minute value
edit_sec  out  8  working second value
hour_set  out  8  committed hour
min_set  out  8  committed minute
sec_set  out  8  committed second
set_valid  out  1  one-cycle pulse: committed values updated
editing  out  1  high in any EDIT state
field_sel  out  2  0=none, 1=hour, 2=min, 3=sec
blink  out  1  blink phase for the selected field

Behaviour:
- Reset (async, rst_n low): state IDLE. All 8-bit outputs = 0, except edit_hour = hour_set = HOUR_MIN. set_valid = 0, editing = 0, field_sel = 0, blink = 0. Hold and blink counters = 0.
- All outputs are registered. A key effect sampled at edge N is visible after edge N.
- FSM states: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC.
  - IDLE + key_mode: load edit_* from cur_*, then go to EDIT_HOUR.
  - Load clamping: a cur_hour outside [HOUR_MIN, HOUR_MAX] loads HOUR_MIN; cur_min or cur_sec > 59 loads 0.
  - EDIT_HOUR + key_mode -> EDIT_MIN.
  - EDIT_MIN + key_mode -> EDIT_SEC.
  - EDIT_SEC + key_mode: copy edit_* to *_set, pulse set_valid for exactly one cycle (same edge as the copy), go to IDLE.
  - Any EDIT state + key_cancel: go to IDLE; *_set unchanged; no set_valid.
  - IDLE ignores key_cancel, key_up and key_down.
- Priority within one cycle: key_cancel > key_mode > up/down. Up/down is ignored in a cycle where mode or cancel is acted on.
- Adjust, selected field only:
  - Hour: up at HOUR_MAX -> HOUR_MIN; down at HOUR_MIN -> HOUR_MAX.
  - Minute/second: up at 59 -> 0; down at 0 -> 59.
  - Non-selected fields never change.
- Hold-to-repeat:
  - Let t0 be the first cycle the active key is sampled high (previous sample low).
  - Steps occur at t0, t0+HOLD_CYCLES, then every REPEAT_CYCLES while the key stays high.
  - Releasing the key clears the hold counter.
  - key_up and key_down both high: no step; hold counter cleared. Releasing one of them makes the remaining key count as a new t0.
  - A field change (key_mode) clears the hold counter. A key still held after the field change does not step until it is released and pressed again.
- Blink:
  - In IDLE: blink = 0 and its counter is held at 0.
  - On entry to EDIT_HOUR and on each field change: blink = 1, counter cleared.
  - Otherwise blink toggles every BLINK_CYCLES cycles.
  - Any adjust step forces blink = 1 and clears the counter, so the value stays visible while it is being changed.
- editing and field_sel follow the state registered on the same edge.
- Reset asserted mid-edit aborts immediately to the reset values; no commit.

Test Plan:
(Bench params: HOUR_MIN=0, HOUR_MAX=23, HOLD_CYCLES=4, REPEAT_CYCLES=2, BLINK_CYCLES=3.)
1. Full set flow: cur=10:20:30; mode; up x2 pulses (1-cycle high, separated); mode; down x1; mode; up x1; mode -> hour_set=12, min_set=19, sec_set=31; set_valid high exactly 1 cycle; editing=0.
2. Wrap boundaries: cur=23:00:59; hour up -> edit_hour=0; next field, down -> edit_min=59; sec up -> edit_sec=0. Repeat with HOUR_MIN=1, HOUR_MAX=12, cur_hour=1, down -> 12.
3. Auto-repeat: EDIT_MIN, edit_min=5, key_up held 10 cycles from t0 -> steps at t0, t0+4, t0+6, t0+8 -> edit_min=9. key_up+key_down held together 10 cycles -> no change.
4. Cancel and priority: edit hour to 15 from cur 08; key_cancel -> hour_set unchanged (0), no set_valid, field_sel=0. Same cycle key_mode+key_cancel in EDIT_SEC -> cancel wins, no commit.
5. Clamp on load: cur=30:75:60, mode -> edit_hour=0, edit_min=0, edit_sec=0, field_sel=1, blink=1.
6. Reset mid-edit: in EDIT_MIN with edits pending, pulse rst_n low for 1 cycle -> all outputs at reset values immediately (async); following key_mode reloads from cur_*.
